// File: rtl/klotski_board_decoder.sv
// klotski_board_decoder: sequences the grid sampler, thresholds and decodes 16 tile IDs,
// validates the permutation, debounces across frames and publishes a stable 4x4 board.
module klotski_board_decoder #(
   parameter int THRESHOLD     = 6,
   parameter int STABLE_FRAMES = 2,
   parameter int TIMEOUT_CYC   = 2000000
) (
   input  logic                   i_Clk,
   input  logic                   i_rst_n,
   input  logic                   i_enable,
   output logic                   o_scan_start,
   input  logic                   i_scan_done,
   input  logic [7:0][7:0][3:0]   i_red_sum,
   output logic [3:0][3:0][3:0]   o_board,
   output logic [3:0]             o_blank_pos,
   output logic                   o_board_valid,
   output logic                   o_updated,
   output logic                   o_frame_err,
   output logic                   o_timeout
);
   localparam logic [3:0]  TH   = 4'(THRESHOLD);
   localparam logic [2:0]  SF   = 3'(STABLE_FRAMES);
   localparam logic [20:0] TLIM = 21'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DECODE, S_CHECK, S_PUBLISH} state_t;
   state_t state, state_nx;

   logic [7:0][7:0][3:0] snap;
   logic [3:0][3:0][3:0] cand, prev;
   logic [15:0]          seen;
   logic [2:0]           stable;
   logic [20:0]          tmo_cnt;
   logic [3:0]           t, id, blank;
   logic                 last_ok, tmo_hit, valid, publish;
   logic [2:0]           y0, y1, x0, x1;

   // Tile t covers the 2x2 cell block at rows 2r..2r+1, cols 2c..2c+1.
   assign y0 = {t[3:2], 1'b0};
   assign y1 = {t[3:2], 1'b1};
   assign x0 = {t[1:0], 1'b0};
   assign x1 = {t[1:0], 1'b1};
   assign id = {snap[y0][x0] > TH, snap[y0][x1] > TH, snap[y1][x0] > TH, snap[y1][x1] > TH};
   assign tmo_hit = tmo_cnt == TLIM;
   assign valid = &seen;
   assign publish = last_ok && stable >= SF && (!o_board_valid || cand != o_board);

   always_comb begin
      blank = 4'd0;
      for (int i = 0; i < 16; i++)
         if (cand[i[3:2]][i[1:0]] == 4'd0) blank = i[3:0];
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    state_nx = i_enable ? S_REQ : S_IDLE;
         S_REQ:     state_nx = S_WAIT;
         S_WAIT:    state_nx = i_scan_done ? S_DECODE : (tmo_hit ? S_REQ : S_WAIT);
         S_DECODE:  state_nx = (t == 4'd15) ? S_CHECK : S_DECODE;
         S_CHECK:   state_nx = S_PUBLISH;
         S_PUBLISH: state_nx = i_enable ? S_REQ : S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_rst_n)
      if (!i_rst_n) state <= S_IDLE;
      else state <= state_nx;

   // Pulses are registered from the state that decides them, so each appears one cycle later.
   always_ff @(posedge i_Clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_scan_start  <= 1'b0;
         o_timeout     <= 1'b0;
         o_frame_err   <= 1'b0;
         o_updated     <= 1'b0;
         o_board       <= '0;
         o_blank_pos   <= 4'd0;
         o_board_valid <= 1'b0;
         snap          <= '0;
         cand          <= '0;
         prev          <= '0;
         seen          <= 16'd0;
         stable        <= 3'd0;
         tmo_cnt       <= 21'd0;
         t             <= 4'd0;
         last_ok       <= 1'b0;
      end else begin
         o_scan_start <= state == S_REQ;
         o_timeout    <= state == S_WAIT && !i_scan_done && tmo_hit;
         o_frame_err  <= state == S_CHECK && !valid;
         o_updated    <= state == S_PUBLISH && publish;
         if (state == S_REQ) tmo_cnt <= 21'd0;
         if (state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 21'd1;
            if (i_scan_done) begin
               snap <= i_red_sum;
               t    <= 4'd0;
               seen <= 16'd0;
            end else if (tmo_hit) stable <= 3'd0;
         end
         if (state == S_DECODE) begin
            cand[t[3:2]][t[1:0]] <= id;
            seen[id]             <= 1'b1;
            t                    <= t + 4'd1;
         end
         if (state == S_CHECK) begin
            last_ok <= valid;
            if (!valid) stable <= 3'd0;
            else begin
               prev   <= cand;
               stable <= (cand != prev) ? 3'd1 : (stable >= SF ? SF : stable + 3'd1);
            end
         end
         if (state == S_PUBLISH && publish) begin
            o_board       <= cand;
            o_blank_pos   <= blank;
            o_board_valid <= 1'b1;
         end
      end
   end
endmodule

// File: doc/klotski_board_decoder.md
Name: klotski_board_decoder

Overview:
- Sits directly downstream of the VGA grid sampler, which produces an 8x8 array of 4-bit red sums and a done pulse.
- Sequences the sampler: issues a scan-start pulse, waits for scan done, then thresholds the 64 sums into bits.
- Groups the bits into 16 four-bit tile IDs, checks that the 16 IDs form a valid permutation, and debounces across frames.
- Publishes a stable 4x4 Klotski board and the blank-tile position to the solver/display logic.

Parameters:
- THRESHOLD, 6: a cell bit is 1 when its red sum is strictly greater than THRESHOLD (4-bit compare).
- STABLE_FRAMES, 2: number of consecutive identical valid frames required before publishing (range 1..7).
- TIMEOUT_CYC, 2000000: S_WAIT cycle limit, roughly 3 frames of 1056x628 pixels; the timeout counter is 21 bits.

Ports:
- i_Clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  level; high = scan continuously
- o_scan_start  out  1  one-cycle pulse to the sampler's start input
- i_scan_done  in  1  sampler done pulse
- i_red_sum  in  [7:0][7:0][3:0]  sampler sums, indexed [row][col]
- o_board  out  [3:0][3:0][3:0]  published tile IDs, indexed [row][col]; ID 0 = blank
- o_blank_pos  out  4  {row,col} of the ID-0 tile in o_board
- o_board_valid  out  1  high once any board has been published; sticky until reset
- o_updated  out  1  one-cycle pulse when o_board changes
- o_frame_err  out  1  one-cycle pulse when a frame fails the permutation check
- o_timeout  out  1  one-cycle pulse when a scan times out

Behaviour:
- Reset (asynchronous): state S_IDLE. All outputs 0. Snapshot, candidate, previous candidate, seen mask, stable count and timeout counter all 0.
- Every output is registered; there are no combinational paths from input to output.
- S_IDLE: if i_enable=1, go to S_REQ.
- S_REQ: o_scan_start=1 for exactly this cycle; clear the timeout counter; go to S_WAIT.
- S_WAIT: increment the timeout counter each cycle.
  - If i_scan_done=1: latch i_red_sum into the snapshot on this edge; go to S_DECODE with tile index 0. Done takes priority over timeout in the same cycle.
  - Else if counter == TIMEOUT_CYC-1: pulse o_timeout, reset stable count to 0, go to S_REQ.
- i_scan_done outside S_WAIT is ignored, and i_red_sum is never sampled outside that edge.
- S_DECODE: one tile per cycle, index t = 0..15, with r = t[3:2] and c = t[1:0].
  - Each cell bit b[y][x] = snapshot[y][x] > THRESHOLD.
  - id = {b[2r][2c], b[2r][2c+1], b[2r+1][2c], b[2r+1][2c+1]}, MSB first.
  - Write candidate[r][c] = id and set seen[id].
  - After t=15 go to S_CHECK. Clear seen at S_DECODE entry.
- S_CHECK: valid iff seen == 16'hFFFF.
  - Invalid: pulse o_frame_err, stable count = 0, go to S_PUBLISH without publishing.
  - Valid and candidate == previous candidate: stable count = min(count+1, STABLE_FRAMES).
  - Valid and candidate differs: stable count = 1.
  - Valid in either case: previous candidate = candidate.
- S_PUBLISH: if the last check was valid, count >= STABLE_FRAMES, and (o_board_valid == 0 or candidate != o_board):
  - o_board = candidate, o_blank_pos = position of ID 0, o_board_valid = 1, pulse o_updated.
  - Then go to S_REQ if i_enable=1, else S_IDLE.
- Latency: o_board and o_updated change on the 18th edge after the edge that samples i_scan_done.
- i_enable low mid-scan: the current frame completes through S_PUBLISH, then the block goes to S_IDLE.
- Reset mid-scan: the block returns immediately to reset values; any partial frame is discarded.
- A re-published identical board produces no o_updated pulse.
- o_scan_start, o_updated, o_frame_err and o_timeout are never high for two consecutive cycles.

Test Plan:
1. Reset, then i_enable=1. The sampler returns done 100 cycles after o_scan_start with a solved board: tile (r,c) has ID 4r+c, cell sum 12 for bit 1 and 0 for bit 0. Required: no publish after frame 1. After frame 2, o_updated pulses 18 cycles after done, o_board[r][c]=4r+c, o_blank_pos=0, o_board_valid=1.
2. Same as test 1, then swap IDs 0 and 5 for two frames. Required: o_updated pulses after the second swapped frame, o_board[0][0]=5, o_board[1][1]=0, o_blank_pos=4'b0101.
3. Frame with two tiles decoding to ID 3 (ID 7 missing). Required: o_frame_err pulse, o_board unchanged, stable count reset so the next valid frame alone does not publish.
4. Cell sums exactly 6 versus 7 with THRESHOLD=6. Required: a sum of 6 decodes to bit 0, a sum of 7 to bit 1; verify via the resulting tile ID.
5. Sampler never answers. Required: o_timeout pulses after TIMEOUT_CYC cycles in S_WAIT, o_scan_start re-pulses the next cycle. i_scan_done asserted in the same cycle as the limit is accepted and no timeout pulse occurs.
6. Reset asserted during S_DECODE, and separately i_enable dropped during S_WAIT. Required: reset clears all outputs asynchronously. With i_enable dropped, the frame finishes and the block idles with no further o_scan_start.
